// File: rtl/soft_fifo_thresh.sv
// rtl/soft_fifo_thresh.sv - register-based FIFO, arbitrary DEPTH, count and runtime almost-full/almost-empty thresholds
// Optional sticky overflow/underflow flags enabled by defining SOFT_FIFO_ERR_EN.
module soft_fifo_thresh #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 384,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  input  logic [CW-1:0]    af_level,
  input  logic [CW-1:0]    ae_level,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, full_q, almost_full_q, almost_empty_q;
  logic             wr_acc, rd_acc;

  assign wr_acc = wrreq & ~full_q;
  assign rd_acc = rdreq & ~empty_q;

  // Flags are derived from the next count so they move in the same cycle as count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
      if (rd_acc) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (flush) begin
        empty_q        <= 1'b1;
        full_q         <= 1'b0;
        almost_full_q  <= 1'b0;
        almost_empty_q <= 1'b1;
      end else begin
        empty_q        <= (count_d == '0);
        full_q         <= (count_d == DEPTH_C);
        almost_full_q  <= (count_d >= af_level);
        almost_empty_q <= (count_d <= ae_level);
      end
    end
  end

  // Storage is deliberately not reset; a flushed write never lands.
  always_ff @(posedge clock) begin
    if (wr_acc && !flush) mem_q[wr_ptr_q] <= data;
  end

  assign q            = mem_q[rd_ptr_q];
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;

`ifdef SOFT_FIFO_ERR_EN
  logic overflow_q, underflow_q;

  // Sticky until reset; flush leaves them alone.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wrreq && full_q)  overflow_q  <= 1'b1;
      if (rdreq && empty_q) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
